// File: rtl/sd_pkg.sv
// Shared definitions for the SD-over-SPI command path.
// Holds command numbers, R1 bit positions, the fill byte and the FSM encoding.
package sd_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_POLL,
    ST_EXTRA,
    ST_TRAIL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7+x^3+1, init 0) over a 40-bit command prefix.
// Ports: data_i = frame bytes 1..5 MSB first, crc_o = 7-bit CRC.
module sd_crc7 (
  input  logic [39:0] data_i,
  output logic [6:0]  crc_o
);

  logic [6:0] crc;
  logic       fb;

  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data_i[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

  assign crc_o = crc;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI command framer: PRE fill, 6-byte frame, R1 poll, optional R3/R7 tail.
// Ports: Cmd* request, Resp* result pulse, Byte* transceiver link, SPI_CS.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int         PollLimit = 8,
  parameter logic [7:0] FillByte  = FILL_BYTE
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [5:0]  CmdIndex,
  input  logic [31:0] CmdArg,
  input  logic        CmdLongResp,
  output logic        RespValid,
  output logic [7:0]  RespR1,
  output logic [31:0] RespExtra,
  output logic        RespTimeout,
  output logic        ByteStart,
  output logic [7:0]  ByteTx,
  input  logic        ByteBusy,
  input  logic        ByteDone,
  input  logic [7:0]  ByteRx,
  output logic        SPI_CS
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  poll_q, poll_d;
  logic        out_q, out_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;
  logic [39:0] frame_q, frame_d;
  logic        long_q, long_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] extra_q, extra_d;
  logic        tmo_q, tmo_d;
  logic        rv_q, rv_d;
  logic        cs_q, cs_d;

  logic [6:0]  crc;
  logic [7:0]  frame_byte;
  logic [7:0]  byte_sel;
  logic        need_byte;
  logic        done_ok;

  sd_crc7 u_crc (
    .data_i (frame_q),
    .crc_o  (crc)
  );

  always_comb begin
    frame_byte = FillByte;
    unique case (cnt_q)
      3'd0:    frame_byte = frame_q[39:32];
      3'd1:    frame_byte = frame_q[31:24];
      3'd2:    frame_byte = frame_q[23:16];
      3'd3:    frame_byte = frame_q[15:8];
      3'd4:    frame_byte = frame_q[7:0];
      3'd5:    frame_byte = {crc, 1'b1};
      default: frame_byte = FillByte;
    endcase
  end

  assign byte_sel  = (state_q == ST_SEND) ? frame_byte : FillByte;
  assign need_byte = state_q inside {ST_PRE, ST_SEND, ST_POLL,
                                     ST_EXTRA, ST_TRAIL};
  // A done pulse only counts while our own exchange is in flight.
  assign done_ok   = ByteDone & out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    out_d   = out_q;
    start_d = 1'b0;
    tx_d    = tx_q;
    frame_d = frame_q;
    long_d  = long_q;
    r1_d    = r1_q;
    extra_d = extra_q;
    tmo_d   = tmo_q;
    rv_d    = 1'b0;

    if (done_ok) out_d = 1'b0;
    if (need_byte && !out_q && !ByteBusy) begin
      start_d = 1'b1;
      out_d   = 1'b1;
      tx_d    = byte_sel;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          frame_d = {2'b01, CmdIndex, CmdArg};
          long_d  = CmdLongResp;
          r1_d    = 8'hFF;
          extra_d = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          poll_d  = '0;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (done_ok) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (done_ok) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d   = '0;
            poll_d  = '0;
            state_d = ST_POLL;
          end
        end
      end
      ST_POLL: begin
        if (done_ok) begin
          if (!ByteRx[7]) begin
            r1_d = ByteRx;
            if (long_q && !ByteRx[R1_ILLEGAL]) state_d = ST_EXTRA;
            else state_d = ST_TRAIL;
          end else begin
            poll_d = poll_q + 8'd1;
            if (poll_q == 8'(PollLimit - 1)) begin
              tmo_d   = 1'b1;
              r1_d    = 8'hFF;
              state_d = ST_TRAIL;
            end
          end
        end
      end
      ST_EXTRA: begin
        if (done_ok) begin
          extra_d = {extra_q[23:0], ByteRx};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = ST_TRAIL;
          end
        end
      end
      ST_TRAIL: begin
        if (done_ok) begin
          rv_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // CS follows the next state so it drops with PRE and rises with TRAIL.
  assign cs_d = !(state_d inside {ST_PRE, ST_SEND, ST_POLL, ST_EXTRA});

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      out_q   <= 1'b0;
      start_q <= 1'b0;
      tx_q    <= 8'hFF;
      frame_q <= '0;
      long_q  <= 1'b0;
      r1_q    <= 8'hFF;
      extra_q <= '0;
      tmo_q   <= 1'b0;
      rv_q    <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      out_q   <= out_d;
      start_q <= start_d;
      tx_q    <= tx_d;
      frame_q <= frame_d;
      long_q  <= long_d;
      r1_q    <= r1_d;
      extra_q <= extra_d;
      tmo_q   <= tmo_d;
      rv_q    <= rv_d;
      cs_q    <= cs_d;
    end
  end

  assign CmdReady    = (state_q == ST_IDLE);
  assign RespValid   = rv_q;
  assign RespR1      = r1_q;
  assign RespExtra   = extra_q;
  assign RespTimeout = tmo_q;
  assign ByteStart   = start_q;
  assign ByteTx      = tx_q;
  assign SPI_CS      = cs_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer with a card/transceiver model.
// Expected byte streams and responses are planned per command from the rules.
module tb_sd_cmd_sequencer;

  localparam int POLL = 8;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [5:0]  CmdIndex = '0;
  logic [31:0] CmdArg = '0;
  logic        CmdLongResp = 1'b0;
  logic        RespValid;
  logic [7:0]  RespR1;
  logic [31:0] RespExtra;
  logic        RespTimeout;
  logic        ByteStart;
  logic [7:0]  ByteTx;
  logic        ByteBusy = 1'b0;
  logic        ByteDone = 1'b0;
  logic [7:0]  ByteRx = 8'hFF;
  logic        SPI_CS;

  sd_cmd_sequencer #(.PollLimit(POLL)) dut (
    .MasterCLK   (MasterCLK),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdIndex    (CmdIndex),
    .CmdArg      (CmdArg),
    .CmdLongResp (CmdLongResp),
    .RespValid   (RespValid),
    .RespR1      (RespR1),
    .RespExtra   (RespExtra),
    .RespTimeout (RespTimeout),
    .ByteStart   (ByteStart),
    .ByteTx      (ByteTx),
    .ByteBusy    (ByteBusy),
    .ByteDone    (ByteDone),
    .ByteRx      (ByteRx),
    .SPI_CS      (SPI_CS)
  );

  always #5 MasterCLK = ~MasterCLK;

  typedef struct {
    logic [7:0]  r1;
    logic [31:0] ex;
    logic        tmo;
  } resp_t;

  logic [7:0] exp_tx[$];
  logic       exp_cs[$];
  logic [7:0] rx_q[$];
  resp_t      exp_resp[$];
  logic [7:0] card[$];

  int nchk = 0;
  int nerr = 0;
  int nresp = 0;
  int nstart = 0;
  logic stray = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // CRC7 as the remainder of (msg * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic push(logic [7:0] tx, logic cs, logic [7:0] rx);
    exp_tx.push_back(tx);
    exp_cs.push_back(cs);
    rx_q.push_back(rx);
  endtask

  task automatic plan(logic [5:0] idx, logic [31:0] arg, logic lng);
    logic [39:0] pre;
    resp_t rs;
    int p;
    logic [7:0] b;
    logic found;
    pre = {2'b01, idx, arg};
    push(8'hFF, 1'b0, 8'hFF);
    for (int k = 0; k < 5; k++)
      push(pre[39 - 8*k -: 8], 1'b0, 8'hFF);
    push({crc7(pre), 1'b1}, 1'b0, 8'hFF);
    rs.r1 = 8'hFF; rs.ex = '0; rs.tmo = 1'b1;
    found = 1'b0;
    p = 0;
    while (!found && p < POLL) begin
      b = (p < card.size()) ? card[p] : 8'hFF;
      push(8'hFF, 1'b0, b);
      if (!b[7]) begin
        found = 1'b1;
        rs.r1 = b;
        rs.tmo = 1'b0;
      end
      p++;
    end
    if (found && lng && !rs.r1[2]) begin
      for (int k = 0; k < 4; k++) begin
        b = (p + k < card.size()) ? card[p + k] : 8'hFF;
        push(8'hFF, 1'b0, b);
        rs.ex = rs.ex | ({24'b0, b} << (24 - 8*k));
      end
    end
    push(8'hFF, 1'b1, 8'hFF);
    exp_resp.push_back(rs);
  endtask

  initial begin : model
    logic pend;
    int   dly;
    logic in_cmd, pv, pr;
    resp_t rs;
    pend = 1'b0; dly = 0; in_cmd = 1'b0; pv = 1'b0; pr = 1'b0;
    forever begin
      @(posedge MasterCLK);
      #1;
      if (!Reset) begin
        pend = 1'b0; ByteBusy = 1'b0; ByteDone = 1'b0;
        in_cmd = 1'b0; pv = 1'b0; pr = 1'b0;
        exp_tx.delete(); exp_cs.delete();
        rx_q.delete(); exp_resp.delete();
        continue;
      end
      if (pv && pr) in_cmd = 1'b1;
      if (in_cmd) chk("ready_while_busy", CmdReady, 0);
      ByteDone = 1'b0;
      if (stray) begin
        ByteDone = 1'b1;
        stray = 1'b0;
      end
      if (ByteStart) begin
        nstart++;
        chk("start_overlap", pend, 0);
        chk("byte_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          chk("byte_tx", ByteTx, exp_tx.pop_front());
          chk("byte_cs", SPI_CS, exp_cs.pop_front());
        end
        pend = 1'b1; dly = 3; ByteBusy = 1'b1;
      end else if (pend) begin
        dly--;
        if (dly == 0) begin
          pend = 1'b0; ByteBusy = 1'b0; ByteDone = 1'b1;
          ByteRx = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
        end
      end
      if (RespValid) begin
        nresp++;
        in_cmd = 1'b0;
        chk("resp_expected", exp_resp.size() != 0, 1);
        if (exp_resp.size() != 0) begin
          rs = exp_resp.pop_front();
          chk("resp_r1", RespR1, rs.r1);
          chk("resp_extra", RespExtra, rs.ex);
          chk("resp_tmo", RespTimeout, rs.tmo);
          chk("resp_cs", SPI_CS, 1);
        end
      end
      pv = CmdValid;
      pr = CmdReady;
    end
  end

  task automatic issue(logic [5:0] i, logic [31:0] a, logic l);
    @(negedge MasterCLK);
    CmdValid = 1'b1; CmdIndex = i; CmdArg = a; CmdLongResp = l;
    @(negedge MasterCLK);
    CmdValid = 1'b0;
  endtask

  task automatic wait_resp(int target);
    int n;
    n = 0;
    while (nresp < target && n < 3000) begin
      @(negedge MasterCLK);
      n++;
    end
    chk("resp_wait", nresp >= target, 1);
    chk("bytes_left", exp_tx.size(), 0);
  endtask

  initial begin : stim
    int base, sb, n;
    chk("crc_cmd0", crc7({8'h40, 32'h0}), 7'h4A);
    chk("crc_cmd8", crc7({8'h48, 32'h1AA}), 7'h43);
    #12;
    chk("rst_ready", CmdReady, 1);
    chk("rst_cs", SPI_CS, 1);
    chk("rst_start", ByteStart, 0);
    chk("rst_tx", ByteTx, 8'hFF);
    chk("rst_rv", RespValid, 0);
    chk("rst_r1", RespR1, 8'hFF);
    chk("rst_extra", RespExtra, 0);
    chk("rst_tmo", RespTimeout, 0);
    @(negedge MasterCLK);
    Reset = 1'b1;
    repeat (2) @(negedge MasterCLK);

    stray = 1'b1;
    repeat (4) @(negedge MasterCLK);
    chk("stray_ready", CmdReady, 1);
    chk("stray_starts", nstart, 0);

    card.delete(); card.push_back(8'hFF); card.push_back(8'h01);
    plan(6'd0, 32'h0, 1'b0);
    chk("cmd0_crc_byte", exp_tx[6], 8'h95);
    issue(6'd0, 32'h0, 1'b0);
    wait_resp(1);
    chk("cmd0_r1", RespR1, 8'h01);
    chk("cmd0_extra", RespExtra, 0);

    card.delete();
    card.push_back(8'h01); card.push_back(8'h00); card.push_back(8'h00);
    card.push_back(8'h01); card.push_back(8'hAA);
    plan(6'd8, 32'h1AA, 1'b1);
    chk("cmd8_crc_byte", exp_tx[6], 8'h87);
    issue(6'd8, 32'h1AA, 1'b1);
    wait_resp(2);
    chk("cmd8_extra", RespExtra, 32'h0000_01AA);

    card.delete(); card.push_back(8'h05);
    sb = nstart;
    plan(6'd8, 32'h1AA, 1'b1);
    issue(6'd8, 32'h1AA, 1'b1);
    wait_resp(3);
    chk("old_bytes_after_pre", nstart - sb - 1, 8);
    chk("old_extra", RespExtra, 0);

    card.delete();
    sb = nstart;
    plan(6'd58, 32'h0, 1'b1);
    issue(6'd58, 32'h0, 1'b1);
    wait_resp(4);
    chk("tmo_bytes", nstart - sb, 1 + 6 + POLL + 1);
    chk("tmo_flag", RespTimeout, 1);
    chk("tmo_r1", RespR1, 8'hFF);
    repeat (5) @(negedge MasterCLK);
    chk("tmo_one_resp", nresp, 4);

    card.delete(); card.push_back(8'h00);
    sb = nstart;
    plan(6'd17, 32'h0000_0200, 1'b0);
    issue(6'd17, 32'h0000_0200, 1'b0);
    n = 0;
    while (nstart < sb + 4 && n < 500) begin
      @(negedge MasterCLK);
      n++;
    end
    chk("third_send_seen", nstart >= sb + 4, 1);
    chk("mid_cs_low", SPI_CS, 0);
    Reset = 1'b0;
    #1;
    chk("abort_cs", SPI_CS, 1);
    chk("abort_ready", CmdReady, 1);
    base = nresp;
    repeat (3) @(negedge MasterCLK);
    Reset = 1'b1;
    repeat (2) @(negedge MasterCLK);
    chk("abort_no_resp", nresp, base);
    card.delete(); card.push_back(8'h01);
    plan(6'd0, 32'h0, 1'b0);
    issue(6'd0, 32'h0, 1'b0);
    wait_resp(base + 1);
    repeat (5) @(negedge MasterCLK);
    chk("post_abort_resp", nresp, base + 1);

    card.delete(); card.push_back(8'h01);
    plan(6'd55, 32'h0, 1'b0);
    plan(6'd55, 32'h0, 1'b0);
    base = nresp;
    @(negedge MasterCLK);
    CmdValid = 1'b1; CmdIndex = 6'd55; CmdArg = 32'h0; CmdLongResp = 1'b0;
    n = 0;
    while (nresp < base + 2 && n < 3000) begin
      @(negedge MasterCLK);
      n++;
    end
    CmdValid = 1'b0;
    chk("held_two_resp", nresp, base + 2);
    repeat (10) @(negedge MasterCLK);
    chk("held_no_third", nresp, base + 2);
    chk("held_bytes_left", exp_tx.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
